uart_transmitter: RTL and testbench

//  Serialises 8-bit words into UART frames on TxD: start(0), D0..D7 LSB first, even parity, stop(1).

---
 rtl/uart_transmitter.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_uart_transmitter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
//
// Serialises 8-bit words into UART frames on TxD: start bit (0), D0..D7 LSB
// first, even parity, stop bit (1). A built-in tick generator produces
// OVERSAMPLE ticks per bit. This is the same rate the downstream receiver
// samples at. Each bit lasts OVERSAMPLE ticks.
//
// Build option:
//   UART_TX_FIFO_EN  defined   -> FIFO_DEPTH-entry write FIFO ahead of the
//                                 shifter. The head entry is the frame on
//                                 the wire and is popped when its stop bit
//                                 ends.
//                    undefined -> the shift register is the only word store;
//                                 Tx_FULL == Tx_BUSY.
//
// Ports:
//   clk          in   1  system clock
//   reset        in   1  asynchronous, active-high
//   Tx_DATA      in   8  word to send, sampled when Tx_WR=1
//   Tx_WR        in   1  write strobe, one cycle per word
//   Tx_EN        in   1  transmitter enable (gates accepts and frame starts)
//   baud_select  in   3  000=300 ... 111=115200, latched at each frame start
//   TxD          out  1  serial line, idle high, registered
//   Tx_BUSY      out  1  frame in progress or buffered words pending
//   Tx_FULL      out  1  no room for another Tx_WR
// ---------------------------------------------------------------------------
module uart_transmitter #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Tx_DATA,
    input  logic       Tx_WR,
    input  logic       Tx_EN,
    input  logic [2:0] baud_select,
    output logic       TxD,
    output logic       Tx_BUSY,
    output logic       Tx_FULL
);

    // Rounded divisors: (CLK_HZ + baud*OVERSAMPLE/2) / (baud*OVERSAMPLE).
    localparam int DIV_0 = (CLK_HZ +    300 * (OVERSAMPLE / 2)) / (   300 * OVERSAMPLE);
    localparam int DIV_1 = (CLK_HZ +   1200 * (OVERSAMPLE / 2)) / (  1200 * OVERSAMPLE);
    localparam int DIV_2 = (CLK_HZ +   4800 * (OVERSAMPLE / 2)) / (  4800 * OVERSAMPLE);
    localparam int DIV_3 = (CLK_HZ +   9600 * (OVERSAMPLE / 2)) / (  9600 * OVERSAMPLE);
    localparam int DIV_4 = (CLK_HZ +  19200 * (OVERSAMPLE / 2)) / ( 19200 * OVERSAMPLE);
    localparam int DIV_5 = (CLK_HZ +  38400 * (OVERSAMPLE / 2)) / ( 38400 * OVERSAMPLE);
    localparam int DIV_6 = (CLK_HZ +  57600 * (OVERSAMPLE / 2)) / ( 57600 * OVERSAMPLE);
    localparam int DIV_7 = (CLK_HZ + 115200 * (OVERSAMPLE / 2)) / (115200 * OVERSAMPLE);

    // The slowest rate has the largest divisor and so sets the counter width.
    localparam int DIV_W = $clog2(DIV_0 + 1);
    localparam int OS_W  = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
        case (sel)
            3'd0:    return DIV_W'(DIV_0);
            3'd1:    return DIV_W'(DIV_1);
            3'd2:    return DIV_W'(DIV_2);
            3'd3:    return DIV_W'(DIV_3);
            3'd4:    return DIV_W'(DIV_4);
            3'd5:    return DIV_W'(DIV_5);
            3'd6:    return DIV_W'(DIV_6);
            default: return DIV_W'(DIV_7);
        endcase
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_tick_cnt;
    logic [OS_W-1:0]  r_os_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_next;
    logic [7:0]       w_start_word;
    logic             r_parity;
    logic             r_txd;
    logic             w_txd_next;
    logic             w_tick;
    logic             w_bit_end;
    logic             w_accept;
    logic             w_start;
    logic             w_can_start;
    logic             w_full;
    logic             w_busy;

    // Tick counter runs only inside a frame; it is cleared at every frame
    // start so the start bit is exactly OVERSAMPLE*div cycles long.
    assign w_tick    = (r_state != S_IDLE) && (r_tick_cnt == r_div - 1'b1);
    assign w_bit_end = w_tick && (r_os_cnt == OS_W'(OVERSAMPLE - 1));
    assign w_accept  = Tx_WR && Tx_EN && !w_full;

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_head_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_avail;
    logic             w_pop;

    // The head entry stays in the FIFO for the whole of its frame. At the
    // end of a stop bit the next word to send therefore sits one past it.
    always_comb begin
        w_head_ptr   = r_rd_ptr;
        w_avail      = (r_count != '0);
        if (r_state == S_STOP) begin
            w_head_ptr = PTR_W'(r_rd_ptr + 1'b1);
            w_avail    = (r_count > (PTR_W + 1)'(1));
        end
        // A word written on the starting edge itself is sent straight from
        // Tx_DATA, so a write into an empty FIFO starts on that edge.
        w_start_word = w_avail ? r_mem[w_head_ptr] : Tx_DATA;
    end

    assign w_can_start = w_avail || w_accept;
    assign w_pop       = (r_state == S_STOP) && w_bit_end;
    assign w_full      = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_busy      = (r_state != S_IDLE) || (r_count != '0);

    // NOTE: storage has no reset; r_count alone decides which entries are
    // valid, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= Tx_DATA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    // Without a FIFO a write is only accepted while idle, and the word is
    // held in the shift register for the duration of its frame.
    assign w_can_start  = w_accept;
    assign w_start_word = Tx_DATA;
    assign w_busy       = (r_state != S_IDLE);
    assign w_full       = w_busy;
`endif

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: all clocked state uses non-blocking assignment so every
            // register samples the pre-edge values of the others.
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned, which
        // would otherwise infer a latch.
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Tx_EN && w_can_start) begin
                    w_state_next = S_START;
                    w_start      = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) w_state_next = S_PARITY;
            end
            S_PARITY: begin
                if (w_bit_end) w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) begin
                    // Back-to-back frames: the next start bit begins on the
                    // edge that ends this stop bit.
                    if (Tx_EN && w_can_start) begin
                        w_state_next = S_START;
                        w_start      = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: shifter and line driver are computed from the next state so
    // TxD is a plain register with no decode after it.
    // -----------------------------------------------------------------------
    always_comb begin
        w_shift_next = r_shift;
        if (w_start) begin
            w_shift_next = w_start_word;
        end else if ((r_state == S_DATA) && w_bit_end) begin
            w_shift_next = {1'b0, r_shift[7:1]};
        end

        w_txd_next = 1'b1;
        case (w_state_next)
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = w_shift_next[0];
            S_PARITY: w_txd_next = r_parity;
            default:  w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_txd      <= 1'b1;
            r_div      <= '0;
            r_tick_cnt <= '0;
            r_os_cnt   <= '0;
            r_bit_idx  <= '0;
        end else begin
            r_shift <= w_shift_next;
            r_txd   <= w_txd_next;
            if (w_start) begin
                // baud_select is captured here only, so changing it
                // mid-frame affects the next frame, not this one.
                r_parity   <= ^w_start_word;
                r_div      <= baud_div(baud_select);
                r_tick_cnt <= '0;
                r_os_cnt   <= '0;
                r_bit_idx  <= '0;
            end else if (r_state != S_IDLE) begin
                if (w_tick) begin
                    r_tick_cnt <= '0;
                    r_os_cnt   <= w_bit_end ? '0 : r_os_cnt + 1'b1;
                    if (w_bit_end && (r_state == S_DATA)) begin
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end else begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end
            end
        end
    end

    assign TxD     = r_txd;
    assign Tx_BUSY = w_busy;
    assign Tx_FULL = w_full;

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
//
// Self-checking bench for uart_transmitter at CLK_HZ = 50 MHz (20 ns clock).
// Words the bench expects to be sent are queued when written. An
// independent line monitor decodes TxD at bit centres and pops/compares each
// frame. Frame, start-bit and busy timings are measured in clock cycles
// against values derived from the divisor table.
// The FIFO scenario is compiled in when UART_TX_FIFO_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_transmitter;

    localparam int DIV_115200 = 27;
    localparam int DIV_9600   = 326;
    localparam int FRAME_115K = 176 * DIV_115200;   // 4752 cycles = 95.04 us
    localparam int LIMIT      = 200_000;

    logic       clk;
    logic       reset;
    logic [7:0] Tx_DATA;
    logic       Tx_WR;
    logic       Tx_EN;
    logic [2:0] baud_select;
    logic       TxD;
    logic       Tx_BUSY;
    logic       Tx_FULL;

    int         n_checks;
    int         n_fail;
    int         mon_div;
    logic [7:0] exp_q[$];

    uart_transmitter dut (
        .clk         (clk),
        .reset       (reset),
        .Tx_DATA     (Tx_DATA),
        .Tx_WR       (Tx_WR),
        .Tx_EN       (Tx_EN),
        .baud_select (baud_select),
        .TxD         (TxD),
        .Tx_BUSY     (Tx_BUSY),
        .Tx_FULL     (Tx_FULL)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One write strobe covering exactly one rising edge.
    task automatic send(input logic [7:0] d, input bit expect_accept);
        @(negedge clk);
        Tx_DATA = d;
        Tx_WR   = 1'b1;
        if (expect_accept) exp_q.push_back(d);
        @(negedge clk);
        Tx_WR   = 1'b0;
    endtask

    // Counts falling-edge samples with Tx_BUSY high; optionally drops Tx_EN
    // after en_off_at samples.
    task automatic measure_busy(input int en_off_at, output int n);
        n = 0;
        while (Tx_BUSY && n < LIMIT) begin
            n++;
            if (n == en_off_at) Tx_EN = 1'b0;
            @(negedge clk);
        end
    endtask

    // Counts cycles over a window where the line is active or busy is set.
    task automatic count_activity(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (!TxD || Tx_BUSY) n++;
        end
    endtask

    task automatic mon_wait(input int n, inout bit ab);
        for (int i = 0; i < n; i++) begin
            if (ab) break;
            @(negedge clk);
            if (reset) ab = 1'b1;
        end
    endtask

    // Line monitor: centre-samples each bit from the falling start edge.
    initial begin : monitor
        bit         prev;
        bit         ab;
        int         div;
        logic       st;
        logic       p;
        logic       sp;
        logic [7:0] d;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset && prev && !TxD) begin
                ab  = 1'b0;
                div = mon_div;
                mon_wait(8 * div - 1, ab);
                st = TxD;
                for (int i = 0; i < 8; i++) begin
                    mon_wait(16 * div, ab);
                    d[i] = TxD;
                end
                mon_wait(16 * div, ab);
                p = TxD;
                mon_wait(16 * div, ab);
                sp = TxD;
                if (!ab) begin
                    check("rx_start", st, 1'b0);
                    check("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("rx_data", d, e);
                        check("rx_parity", p, ^e);
                        check("rx_stop", sp, 1'b1);
                    end
                end
                prev = TxD;
            end else begin
                prev = TxD;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        Tx_WR       = 1'b0;
        Tx_EN       = 1'b1;
        Tx_DATA     = 8'h00;
        baud_select = 3'b111;
        mon_div     = DIV_115200;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd", TxD, 1'b1);
        check("rst_busy", Tx_BUSY, 1'b0);
        check("rst_full", Tx_FULL, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 0x55 at 115200: busy for exactly one frame
        send(8'h55, 1'b1);
        check("full_eq_busy", Tx_FULL, 1'b1);
        measure_busy(-1, n);
        check("busy_0x55", n, FRAME_115K);
        repeat (20) @(negedge clk);

        // 0x89; baud_select changed mid-frame must not alter this frame
        send(8'h89, 1'b1);
        baud_select = 3'b000;
        measure_busy(-1, n);
        check("busy_baud_change", n, FRAME_115K);
        baud_select = 3'b111;
        repeat (20) @(negedge clk);

        // Write while busy is dropped
        send(8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        check("full_when_busy", Tx_FULL, 1'b1);
        send(8'h3C, 1'b0);
        measure_busy(-1, n);
        check("busy_after_drop", n, FRAME_115K - 12);
        count_activity(FRAME_115K, n);
        check("no_extra_frame", n, 0);

        // Tx_EN=0 blocks writes; clearing it mid-frame lets the frame finish
        Tx_EN = 1'b0;
        send(8'hAA, 1'b0);
        count_activity(200, n);
        check("en_off_idle", n, 0);
        Tx_EN = 1'b1;
        send(8'h0F, 1'b1);
        measure_busy(100, n);
        check("busy_en_cleared", n, FRAME_115K);
        send(8'h11, 1'b0);
        count_activity(200, n);
        check("en_off_no_start", n, 0);
        Tx_EN = 1'b1;

        // 9600 start bit length, then reset mid-data
        baud_select = 3'b011;
        mon_div     = DIV_9600;
        send(8'hC3, 1'b1);
        n = 0;
        while (!TxD && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        check("start_bit_9600", n, 16 * DIV_9600);
        repeat (3000) @(negedge clk);
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_txd", TxD, 1'b1);
        check("midrst_busy", Tx_BUSY, 1'b0);
        check("midrst_full", Tx_FULL, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        baud_select = 3'b111;
        mon_div     = DIV_115200;
        repeat (5) @(negedge clk);
        send(8'h96, 1'b1);
        measure_busy(-1, n);
        check("busy_after_reset", n, FRAME_115K);
        repeat (20) @(negedge clk);

`ifdef UART_TX_FIFO_EN
        // Five back-to-back writes into a 4-deep FIFO
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            Tx_DATA = 8'(i + 1);
            Tx_WR   = 1'b1;
            if (i < 4) exp_q.push_back(8'(i + 1));
            @(negedge clk);
            if (i == 2) check("fifo_not_full_3", Tx_FULL, 1'b0);
            if (i == 3) check("fifo_full_4", Tx_FULL, 1'b1);
        end
        Tx_WR = 1'b0;
        measure_busy(-1, n);
        check("fifo_contiguous", n, 4 * FRAME_115K - 4);
        repeat (20) @(negedge clk);
`endif

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
